// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the reservation station slice.
//   - default parameter values for rs_queue / rs_select
//   - rs_entry_t: reference layout of one station entry at default widths
//   - rs_popcount: population count used for the occupancy output
// Optional feature macro: RS_AGE_ORDER_EN (oldest-first selection).
package rs_pkg;

  localparam int unsigned RS_DEPTH     = 4;
  localparam int unsigned RS_TAG_W     = 3;
  localparam int unsigned RS_DATA_W    = 32;
  localparam int unsigned RS_OP_W      = 4;
  localparam int unsigned RS_AGE_W     = $clog2(RS_DEPTH);
  // Upper bound on DEPTH accepted by rs_popcount.
  localparam int unsigned RS_MAX_DEPTH = 64;

  typedef struct packed {
    logic                 busy;
    logic [RS_TAG_W-1:0]  qi;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_DATA_W-1:0] vi;
    logic [RS_DATA_W-1:0] vj;
    logic                 i_rdy;
    logic                 j_rdy;
    logic [RS_TAG_W-1:0]  rob_ix;
    logic [RS_OP_W-1:0]   op;
    logic [RS_AGE_W-1:0]  age;
  } rs_entry_t;

  function automatic int unsigned rs_popcount(input logic [RS_MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < RS_MAX_DEPTH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: combinational dispatch selector.
//   i_ready : per-entry candidate vector (busy and both operands ready)
//   i_age   : per-entry age, only with RS_AGE_ORDER_EN
//   o_idx   : chosen entry index
//   o_found : at least one candidate exists
// RS_AGE_ORDER_EN defined: largest age wins, ties go to the lowest index.
// Otherwise: lowest-index candidate wins.
module rs_select
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            i_ready,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] i_age,
`endif
  output logic [IDX_W-1:0]            o_idx,
  output logic                        o_found
);

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] w_best_age;

  always_comb begin
    o_idx      = '0;
    o_found    = 1'b0;
    w_best_age = '0;
    // Strict compare keeps the lowest index among equal ages.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_ready[i] && (!o_found || (i_age[i] > w_best_age))) begin
        o_idx      = IDX_W'(i);
        w_best_age = i_age[i];
        o_found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_ready[i] && !o_found) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_queue.sv
// rs_queue: parametrised reservation station between issue and one FU.
// Holds up to DEPTH instructions, captures operands from the CDB (also at
// insert time), and dispatches one ready instruction per cycle through a
// stalling output register with a valid/ready handshake.
// Ports:
//   clk_in, rst_in (sync, active-high), flush_in
//   ins_*            : issue-side insert interface, ins_ready_out = free slot
//   cdb_*            : common data bus broadcast
//   out_valid_out, fu_ready_in, rval1_out, rval2_out, op_out, rob_ix_out
//   count_out        : number of busy entries (registered busy vector)
// Optional feature macro: RS_AGE_ORDER_EN (oldest-ready-first dispatch).
module rs_queue
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned TAG_W  = RS_TAG_W,
  parameter int unsigned DATA_W = RS_DATA_W,
  parameter int unsigned OP_W   = RS_OP_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       ins_valid_in,
  output logic                       ins_ready_out,
  input  logic [TAG_W-1:0]           ins_qi_in,
  input  logic [TAG_W-1:0]           ins_qj_in,
  input  logic [DATA_W-1:0]          ins_vi_in,
  input  logic [DATA_W-1:0]          ins_vj_in,
  input  logic                       ins_i_rdy_in,
  input  logic                       ins_j_rdy_in,
  input  logic [TAG_W-1:0]           ins_rob_ix_in,
  input  logic [OP_W-1:0]            ins_op_in,
  input  logic                       cdb_valid_in,
  input  logic [TAG_W-1:0]           cdb_rob_ix_in,
  input  logic [DATA_W-1:0]          cdb_value_in,
  output logic                       out_valid_out,
  input  logic                       fu_ready_in,
  output logic [DATA_W-1:0]          rval1_out,
  output logic [DATA_W-1:0]          rval2_out,
  output logic [OP_W-1:0]            op_out,
  output logic [TAG_W-1:0]           rob_ix_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Entry payload at the instance widths; busy and age live in their own
  // vectors so the selector and occupancy logic can read them directly.
  typedef struct packed {
    logic [TAG_W-1:0]  qi;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vi;
    logic [DATA_W-1:0] vj;
    logic              i_rdy;
    logic              j_rdy;
    logic [TAG_W-1:0]  rob_ix;
    logic [OP_W-1:0]   op;
  } ent_t;

  logic [DEPTH-1:0]        r_busy;
  ent_t                    r_ent [DEPTH];
  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_rval1;
  logic [DATA_W-1:0]       r_rval2;
  logic [OP_W-1:0]         r_op;
  logic [TAG_W-1:0]        r_rob_ix;

  logic [IDX_W-1:0]        w_free_idx;
  logic                    w_has_free;
  logic                    w_ins;
  ent_t                    w_ins_ent;
  logic [DEPTH-1:0]        w_cand;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_sel_found;
  logic                    w_load;
  logic [RS_MAX_DEPTH-1:0] w_busy_ext;

`ifdef RS_AGE_ORDER_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0]            r_age [DEPTH];
  logic [DEPTH-1:0][IDX_W-1:0] w_age_vec;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) w_age_vec[i] = r_age[i];
  end
`endif

  // Lowest-index free slot from the registered busy vector, so a slot freed
  // by this cycle's dispatch load is only reusable next cycle.
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_has_free) begin
        w_free_idx = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  assign ins_ready_out = w_has_free;
  assign w_ins         = ins_valid_in && w_has_free;

  // Insert-time CDB capture for operands that are not yet ready.
  always_comb begin
    w_ins_ent.qi     = ins_qi_in;
    w_ins_ent.qj     = ins_qj_in;
    w_ins_ent.vi     = ins_vi_in;
    w_ins_ent.vj     = ins_vj_in;
    w_ins_ent.i_rdy  = ins_i_rdy_in;
    w_ins_ent.j_rdy  = ins_j_rdy_in;
    w_ins_ent.rob_ix = ins_rob_ix_in;
    w_ins_ent.op     = ins_op_in;
    if (!ins_i_rdy_in && cdb_valid_in && (ins_qi_in == cdb_rob_ix_in)) begin
      w_ins_ent.vi    = cdb_value_in;
      w_ins_ent.i_rdy = 1'b1;
    end
    if (!ins_j_rdy_in && cdb_valid_in && (ins_qj_in == cdb_rob_ix_in)) begin
      w_ins_ent.vj    = cdb_value_in;
      w_ins_ent.j_rdy = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cand[i] = r_busy[i] && r_ent[i].i_rdy && r_ent[i].j_rdy;
    end
  end

  rs_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .i_ready (w_cand),
`ifdef RS_AGE_ORDER_EN
    .i_age   (w_age_vec),
`endif
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  assign w_load = (!r_out_valid || fu_ready_in) && w_sel_found;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_rval1     <= '0;
      r_rval2     <= '0;
      r_op        <= '0;
      r_rob_ix    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i].i_rdy <= 1'b0;
        r_ent[i].j_rdy <= 1'b0;
`ifdef RS_AGE_ORDER_EN
        r_age[i]       <= '0;
`endif
      end
    end else if (flush_in) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i].i_rdy <= 1'b0;
        r_ent[i].j_rdy <= 1'b0;
      end
    end else begin
      // CDB wakeup of waiting operands in busy entries.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && cdb_valid_in) begin
          if (!r_ent[i].i_rdy && (r_ent[i].qi == cdb_rob_ix_in)) begin
            r_ent[i].vi    <= cdb_value_in;
            r_ent[i].i_rdy <= 1'b1;
          end
          if (!r_ent[i].j_rdy && (r_ent[i].qj == cdb_rob_ix_in)) begin
            r_ent[i].vj    <= cdb_value_in;
            r_ent[i].j_rdy <= 1'b1;
          end
        end
      end

      if (w_load) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_out_valid       <= 1'b1;
        r_rval1           <= r_ent[w_sel_idx].vi;
        r_rval2           <= r_ent[w_sel_idx].vj;
        r_op              <= r_ent[w_sel_idx].op;
        r_rob_ix          <= r_ent[w_sel_idx].rob_ix;
      end else if (fu_ready_in) begin
        r_out_valid <= 1'b0;
      end

      // The free slot is never busy, so it cannot collide with the wakeup
      // or the dispatched slot above.
      if (w_ins) begin
        r_busy[w_free_idx] <= 1'b1;
        r_ent[w_free_idx]  <= w_ins_ent;
`ifdef RS_AGE_ORDER_EN
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && (r_age[i] != AGE_MAX)) r_age[i] <= r_age[i] + 1'b1;
        end
        r_age[w_free_idx] <= '0;
`endif
      end
    end
  end

  always_comb begin
    w_busy_ext             = '0;
    w_busy_ext[DEPTH-1:0]  = r_busy;
  end

  assign count_out     = CNT_W'(rs_popcount(w_busy_ext));
  assign out_valid_out = r_out_valid;
  assign rval1_out     = r_rval1;
  assign rval2_out     = r_rval2;
  assign op_out        = r_op;
  assign rob_ix_out    = r_rob_ix;

endmodule

// File: tb/tb_rs_queue.sv
// tb_rs_queue: table-driven bench for rs_queue (DEPTH=4). Each record is
// one clock: inputs applied before the edge, outputs checked 1ns after it.
// Expected dispatch order adapts to RS_AGE_ORDER_EN.
module tb_rs_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, ins_valid_in, ins_ready_out;
  logic [2:0]  ins_qi_in, ins_qj_in, ins_rob_ix_in, cdb_rob_ix_in, rob_ix_out, count_out;
  logic [31:0] ins_vi_in, ins_vj_in, cdb_value_in, rval1_out, rval2_out;
  logic        ins_i_rdy_in, ins_j_rdy_in, cdb_valid_in, out_valid_out, fu_ready_in;
  logic [3:0]  ins_op_in, op_out;

  always #5 clk_in = ~clk_in;

  rs_queue #(.DEPTH(4), .TAG_W(3), .DATA_W(32), .OP_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .ins_valid_in(ins_valid_in), .ins_ready_out(ins_ready_out),
    .ins_qi_in(ins_qi_in), .ins_qj_in(ins_qj_in),
    .ins_vi_in(ins_vi_in), .ins_vj_in(ins_vj_in),
    .ins_i_rdy_in(ins_i_rdy_in), .ins_j_rdy_in(ins_j_rdy_in),
    .ins_rob_ix_in(ins_rob_ix_in), .ins_op_in(ins_op_in),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_value_in(cdb_value_in),
    .out_valid_out(out_valid_out), .fu_ready_in(fu_ready_in),
    .rval1_out(rval1_out), .rval2_out(rval2_out), .op_out(op_out),
    .rob_ix_out(rob_ix_out), .count_out(count_out)
  );

  typedef struct packed {
    logic        fl, iv, ir, jr, cv, fr;
    logic [2:0]  qi, qj, rob, ct;
    logic [31:0] vi, vj, cval;
    logic [3:0]  op;
    logic        e_rdy, e_ov;
    logic [2:0]  e_rob, e_cnt;
    logic [31:0] e_r1, e_r2;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle(input logic fr);
    vec_t v;
    v = '0;
    v.fr = fr;
    return v;
  endfunction

  function automatic vec_t ins(input logic [2:0] rob, input logic ir, input logic [2:0] qi,
                               input logic [31:0] vi, input logic jr, input logic [2:0] qj,
                               input logic [31:0] vj, input logic fr);
    vec_t v;
    v = idle(fr);
    v.iv = 1'b1; v.rob = rob; v.op = {1'b1, rob};
    v.ir = ir; v.qi = qi; v.vi = vi;
    v.jr = jr; v.qj = qj; v.vj = vj;
    return v;
  endfunction

  // Both operands ready, values derived from the ROB index.
  function automatic vec_t R(input logic [2:0] rob, input logic fr);
    return ins(rob, 1'b1, 3'd0, 32'h100 + 32'(rob), 1'b1, 3'd0, 32'h200 + 32'(rob), fr);
  endfunction

  function automatic vec_t cdb(input vec_t vin, input logic [2:0] tag, input logic [31:0] val);
    vec_t v;
    v = vin; v.cv = 1'b1; v.ct = tag; v.cval = val;
    return v;
  endfunction

  function automatic vec_t flush(input vec_t vin);
    vec_t v;
    v = vin; v.fl = 1'b1;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vin, input logic rdy, input logic ov, input logic [2:0] rob,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] cnt);
    vec_t v;
    v = vin; v.e_rdy = rdy; v.e_ov = ov; v.e_rob = rob; v.e_r1 = r1; v.e_r2 = r2; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t en(input vec_t v, input logic [2:0] cnt);
    return ex(v, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, cnt);
  endfunction

  function automatic vec_t eo(input vec_t v, input logic [2:0] rob, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [2:0] cnt);
    return ex(v, 1'b1, 1'b1, rob, r1, r2, cnt);
  endfunction

  function automatic vec_t eoR(input vec_t v, input logic [2:0] rob, input logic [2:0] cnt);
    return eo(v, rob, 32'h100 + 32'(rob), 32'h200 + 32'(rob), cnt);
  endfunction

  task automatic apply(input vec_t v);
    flush_in = v.fl; ins_valid_in = v.iv; fu_ready_in = v.fr;
    ins_qi_in = v.qi; ins_qj_in = v.qj; ins_vi_in = v.vi; ins_vj_in = v.vj;
    ins_i_rdy_in = v.ir; ins_j_rdy_in = v.jr; ins_rob_ix_in = v.rob; ins_op_in = v.op;
    cdb_valid_in = v.cv; cdb_rob_ix_in = v.ct; cdb_value_in = v.cval;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    chk($sformatf("v%0d.ins_ready", k), 32'(ins_ready_out), 32'(v.e_rdy));
    chk($sformatf("v%0d.out_valid", k), 32'(out_valid_out), 32'(v.e_ov));
    chk($sformatf("v%0d.count", k), 32'(count_out), 32'(v.e_cnt));
    if (v.e_ov) begin
      chk($sformatf("v%0d.rob_ix", k), 32'(rob_ix_out), 32'(v.e_rob));
      chk($sformatf("v%0d.op", k), 32'(op_out), 32'({1'b1, v.e_rob}));
      chk($sformatf("v%0d.rval1", k), rval1_out, v.e_r1);
      chk($sformatf("v%0d.rval2", k), rval2_out, v.e_r2);
    end
  endtask

  initial begin
    int lat;
    apply(idle(1'b0));
    rst_in = 1'b1;

    // Back-to-back dispatch of four ready instructions.
    tbl.push_back(en(R(0, 1), 1));
    tbl.push_back(eoR(R(1, 1), 0, 1));
    tbl.push_back(eoR(R(2, 1), 1, 1));
    tbl.push_back(eoR(R(3, 1), 2, 1));
    tbl.push_back(eoR(idle(1), 3, 0));
    tbl.push_back(en(idle(1), 0));
    // Wakeup from a later broadcast; non-matching tag must not wake.
    tbl.push_back(en(cdb(ins(5, 0, 2, 0, 1, 0, 32'h55, 1), 3, 32'hdead), 1));
    tbl.push_back(en(cdb(idle(1), 2, 32'h1234), 1));
    tbl.push_back(eo(idle(1), 5, 32'h1234, 32'h55, 0));
    tbl.push_back(en(idle(1), 0));
    // Insert-time capture; ready operand i (same tag) must not be overwritten.
    tbl.push_back(en(cdb(ins(6, 1, 6, 32'h11, 0, 6, 0, 1), 6, 32'd7), 1));
    tbl.push_back(eo(idle(1), 6, 32'h11, 32'd7, 0));
    tbl.push_back(en(idle(1), 0));
    // Fill with FU stalled, full insert ignored, outputs held.
    tbl.push_back(en(R(0, 0), 1));
    tbl.push_back(eoR(R(1, 0), 0, 1));
    tbl.push_back(eoR(R(2, 0), 0, 2));
    tbl.push_back(eoR(R(3, 0), 0, 3));
    tbl.push_back(ex(R(4, 0), 0, 1, 0, 32'h100, 32'h200, 4));
    tbl.push_back(ex(R(7, 0), 0, 1, 0, 32'h100, 32'h200, 4));
    tbl.push_back(ex(idle(0), 0, 1, 0, 32'h100, 32'h200, 4));
    tbl.push_back(ex(idle(0), 0, 1, 0, 32'h100, 32'h200, 4));
`ifdef RS_AGE_ORDER_EN
    tbl.push_back(eoR(idle(1), 1, 3));
    tbl.push_back(eoR(idle(1), 2, 2));
`else
    tbl.push_back(eoR(idle(1), 2, 3));
    tbl.push_back(eoR(idle(1), 1, 2));
`endif
    tbl.push_back(eoR(idle(1), 3, 1));
    tbl.push_back(eoR(idle(1), 4, 0));
    tbl.push_back(en(idle(1), 0));
    // Older A waits, younger B ready: B goes first in either mode.
    tbl.push_back(en(ins(1, 0, 1, 0, 1, 0, 32'h31, 1), 1));
    tbl.push_back(en(R(2, 1), 2));
    tbl.push_back(eoR(cdb(idle(1), 1, 32'h77), 2, 1));
    tbl.push_back(eo(idle(1), 1, 32'h77, 32'h31, 0));
    tbl.push_back(en(idle(1), 0));
    // Both operands woken by one broadcast, then older A at higher index
    // and younger B at lower index become ready together.
    tbl.push_back(en(ins(7, 0, 7, 0, 0, 7, 0, 1), 1));
    tbl.push_back(en(ins(1, 0, 2, 0, 1, 0, 32'h41, 1), 2));
    tbl.push_back(en(cdb(idle(1), 7, 32'h70), 2));
    tbl.push_back(eo(idle(1), 7, 32'h70, 32'h70, 1));
    tbl.push_back(en(ins(2, 0, 2, 0, 1, 0, 32'h42, 1), 2));
    tbl.push_back(en(cdb(idle(1), 2, 32'h22), 2));
`ifdef RS_AGE_ORDER_EN
    tbl.push_back(eo(idle(1), 1, 32'h22, 32'h41, 1));
    tbl.push_back(eo(idle(1), 2, 32'h22, 32'h42, 0));
`else
    tbl.push_back(eo(idle(1), 2, 32'h22, 32'h42, 1));
    tbl.push_back(eo(idle(1), 1, 32'h22, 32'h41, 0));
`endif
    tbl.push_back(en(idle(1), 0));
    // Flush with three busy and a pending output; same-cycle insert ignored.
    tbl.push_back(en(R(1, 0), 1));
    tbl.push_back(eoR(R(2, 0), 1, 1));
    tbl.push_back(eoR(R(3, 0), 1, 2));
    tbl.push_back(eoR(R(4, 0), 1, 3));
    tbl.push_back(en(flush(cdb(R(5, 0), 1, 32'h99)), 0));
    tbl.push_back(en(idle(1), 0));
    tbl.push_back(en(R(6, 1), 1));
    tbl.push_back(eoR(idle(1), 6, 0));
    tbl.push_back(en(idle(1), 0));

    // Reset state.
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset.ins_ready", 32'(ins_ready_out), 32'd1);
    chk("reset.out_valid", 32'(out_valid_out), 32'd0);
    chk("reset.count", 32'(count_out), 32'd0);
    chk("reset.rval1", rval1_out, 32'd0);
    chk("reset.rval2", rval2_out, 32'd0);
    chk("reset.op", 32'(op_out), 32'd0);
    chk("reset.rob_ix", 32'(rob_ix_out), 32'd0);
    rst_in = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k]);
      @(posedge clk_in);
      #1;
      check_vec(k, tbl[k]);
    end

    // Insert-to-dispatch latency with a bounded wait, then stall hold.
    apply(R(3, 0));
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      apply(idle(1'b0));
      lat++;
    end while (!out_valid_out && lat < 8);
    chk("latency.cycles", 32'(lat), 32'd2);
    chk("latency.rob_ix", 32'(rob_ix_out), 32'd3);
    repeat (3) @(posedge clk_in);
    #1;
    chk("stall.out_valid", 32'(out_valid_out), 32'd1);
    chk("stall.rval1", rval1_out, 32'h103);
    apply(idle(1'b1));
    @(posedge clk_in);
    #1;
    chk("release.out_valid", 32'(out_valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
